branch_inflight_q: RTL

BRANCH_INFLIGHT_Q -- requirements
Module: branch_inflight_q

---
 rtl/branch_pkg.sv | 21 ++
 rtl/branch_inflight_q.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch in-flight queue: entry payload, default PHT index width
// and a saturating counter helper used by the optional statistics.
package branch_pkg;

   localparam int unsigned PC_W             = 32;
   localparam int unsigned GHR_BITS_DEFAULT = 5;
   localparam int unsigned PHT_IDX_MAX_W    = 16;
   localparam int unsigned STAT_W           = 16;

   // pht_idx is sized for the widest supported GHR; narrower queues zero-extend on write
   typedef struct packed {
      logic [PC_W-1:0]          pc;
      logic                     pred_taken;
      logic [PHT_IDX_MAX_W-1:0] pht_idx;
   } branch_entry_t;

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
      return (en && (v != {STAT_W{1'b1}})) ? v + STAT_W'(1) : v;
   endfunction

endpackage

// File: rtl/branch_inflight_q.sv
// In-flight branch FIFO: tracks predicted branches until EX resolves them, trains the
// predictor and redirects fetch on mispredict. Define BRANCH_Q_STATS_EN for resolve/mispredict counters.
module branch_inflight_q
   import branch_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned GHR_BITS = GHR_BITS_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_valid,
   output logic                      push_ready,
   input  logic [PC_W-1:0]           push_pc,
   input  logic                      push_pred_taken,
   input  logic [GHR_BITS-1:0]       push_pht_idx,
   input  logic                      ex_resolve,
   input  logic                      ex_actual_taken,
   input  logic [PC_W-1:0]           ex_target,
   input  logic                      flush,
   output logic                      upd_en,
   output logic                      upd_taken,
   output logic [GHR_BITS-1:0]       upd_pht_idx,
   output logic                      mispredict,
   output logic [PC_W-1:0]           redirect_pc,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty,
   output logic                      err_underflow
`ifdef BRANCH_Q_STATS_EN
   ,
   output logic [STAT_W-1:0]         stat_resolved,
   output logic [STAT_W-1:0]         stat_mispred
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   branch_entry_t           mem_q [DEPTH];
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    empty_q, empty_d;
   logic                    ready_q, ready_d;
   logic                    upd_en_q, upd_en_d;
   logic                    upd_taken_q, upd_taken_d;
   logic [GHR_BITS-1:0]     upd_idx_q, upd_idx_d;
   logic                    mispred_q, mispred_d;
   logic [PC_W-1:0]         redirect_q, redirect_d;
   logic                    err_q, err_d;

   branch_entry_t           head_c;
   branch_entry_t           wr_data_c;
   logic                    wr_en_c;
   logic                    full_c;
   logic                    qempty_c;
   logic                    resolve_ok_c;
   logic                    mispred_c;
   logic                    squash_c;
   logic                    pop_c;
   logic                    push_ok_c;

   // Head decode and resolve/push arbitration
   always_comb begin
      full_c       = (count_q == CW'(DEPTH));
      qempty_c     = (count_q == '0);
      head_c       = mem_q[rd_ptr_q];
      resolve_ok_c = ex_resolve && !qempty_c;
      mispred_c    = resolve_ok_c && (ex_actual_taken != head_c.pred_taken) && !flush;
      squash_c     = mispred_c || flush;
      pop_c        = resolve_ok_c && !squash_c;
      // a full queue still takes a push when a correct resolve frees the head slot
      push_ok_c    = push_valid && !squash_c && (!full_c || pop_c);
      wr_en_c      = push_ok_c;
      wr_data_c.pc         = push_pc;
      wr_data_c.pred_taken = push_pred_taken;
      wr_data_c.pht_idx    = PHT_IDX_MAX_W'(push_pht_idx);
   end

   // Next-state for pointers, occupancy and registered outputs
   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      upd_en_d    = 1'b0;
      upd_taken_d = upd_taken_q;
      upd_idx_d   = upd_idx_q;
      mispred_d   = 1'b0;
      redirect_d  = redirect_q;
      err_d       = err_q | (ex_resolve && qempty_c);

      if (squash_c) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok_c) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_c)     rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push_ok_c) - CW'(pop_c);
      end

      if (resolve_ok_c) begin
         upd_en_d    = 1'b1;
         upd_taken_d = ex_actual_taken;
         upd_idx_d   = GHR_BITS'(head_c.pht_idx);
      end

      if (mispred_c) begin
         mispred_d  = 1'b1;
         redirect_d = ex_actual_taken ? ex_target : head_c.pc + PC_W'(4);
      end

      empty_d = (count_d == '0);
      ready_d = (count_d != CW'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         empty_q     <= 1'b1;
         ready_q     <= 1'b1;
         upd_en_q    <= 1'b0;
         upd_taken_q <= 1'b0;
         upd_idx_q   <= '0;
         mispred_q   <= 1'b0;
         redirect_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         empty_q     <= empty_d;
         ready_q     <= ready_d;
         upd_en_q    <= upd_en_d;
         upd_taken_q <= upd_taken_d;
         upd_idx_q   <= upd_idx_d;
         mispred_q   <= mispred_d;
         redirect_q  <= redirect_d;
         err_q       <= err_d;
      end
   end

   // Entry storage needs no reset: occupancy gates every read
   always_ff @(posedge clk) begin
      if (wr_en_c) mem_q[wr_ptr_q] <= wr_data_c;
   end

   generate
      if (GHR_BITS < PHT_IDX_MAX_W) begin : g_idx_pad
         logic unused_idx_hi;
         assign unused_idx_hi = |head_c.pht_idx[PHT_IDX_MAX_W-1:GHR_BITS];
      end
   endgenerate

   assign push_ready    = ready_q;
   assign count         = count_q;
   assign empty         = empty_q;
   assign upd_en        = upd_en_q;
   assign upd_taken     = upd_taken_q;
   assign upd_pht_idx   = upd_idx_q;
   assign mispredict    = mispred_q;
   assign redirect_pc   = redirect_q;
   assign err_underflow = err_q;

`ifdef BRANCH_Q_STATS_EN
   logic [STAT_W-1:0] stat_res_q, stat_res_d;
   logic [STAT_W-1:0] stat_mis_q, stat_mis_d;

   always_comb begin
      stat_res_d = sat_inc(stat_res_q, resolve_ok_c);
      stat_mis_d = sat_inc(stat_mis_q, mispred_c);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_res_q <= '0;
         stat_mis_q <= '0;
      end else begin
         stat_res_q <= stat_res_d;
         stat_mis_q <= stat_mis_d;
      end
   end

   assign stat_resolved = stat_res_q;
   assign stat_mispred  = stat_mis_q;
`endif

endmodule
